// File: rtl/cmp_seq_ctrl_if.sv
// Request/result bundle between a datapath and cmp_seq_ctrl.
// The master drives start with the operands. The slave (cmp_seq_ctrl)
// returns busy, the done pulse and the held result flags.
interface cmp_seq_ctrl_if #(
  parameter int unsigned SLICE_W = 16,
  parameter int unsigned NSLICE  = 4
);
  logic                        start;
  logic [SLICE_W*NSLICE-1:0]   op_a;
  logic [SLICE_W*NSLICE-1:0]   op_b;
  logic                        busy;
  logic                        done;
  logic                        eq;
  logic                        lt;
  logic                        gt;
  logic                        err;

  modport master (
    output start, op_a, op_b,
    input  busy, done, eq, lt, gt, err
  );

  modport slave (
    input  start, op_a, op_b,
    output busy, done, eq, lt, gt, err
  );
endinterface

// File: rtl/cmp_seq_ctrl.sv
// cmp_seq_ctrl: compares two SLICE_W*NSLICE-bit operands by streaming one
// slice per cycle through a single external 16-bit hex_comparator.
// Default build: slices are fed LSB-first, and the comparator cascade inputs
// are chained from the previous slice's result. Latency is fixed at NSLICE.
// With CMP_EARLY_EXIT_EN defined: slices are fed MSB-first, the cascade is
// held at equal, and the job ends on the first slice that differs.
module cmp_seq_ctrl #(
  parameter int unsigned SLICE_W = 16,
  parameter int unsigned NSLICE  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  cmp_seq_ctrl_if.slave       bus,
  output logic [SLICE_W-1:0]  cmp_a,
  output logic [SLICE_W-1:0]  cmp_b,
  output logic                cmp_e,
  output logic                cmp_l,
  output logic                cmp_g,
  input  logic                cmp_E,
  input  logic                cmp_L,
  input  logic                cmp_G
);

  localparam int unsigned OPW  = SLICE_W * NSLICE;
  localparam int unsigned IDXW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]      state_q;
  logic [IDXW-1:0] idx_q;
  logic [OPW-1:0]  opa_q;
  logic [OPW-1:0]  opb_q;
  logic            eq_q;
  logic            lt_q;
  logic            gt_q;
  logic            err_q;
  logic            done_q;
`ifndef CMP_EARLY_EXIT_EN
  logic [2:0]      casc_q;
`endif

  logic            accept;
  logic            last;
  logic            finish;
  logic            res_onehot;
  logic [IDXW-1:0] sel;

  assign accept     = (state_q == IDLE) && bus.start;
  assign last       = (idx_q == IDXW'(NSLICE - 1));
  assign res_onehot = ( cmp_E & ~cmp_L & ~cmp_G) |
                      (~cmp_E &  cmp_L & ~cmp_G) |
                      (~cmp_E & ~cmp_L &  cmp_G);

`ifdef CMP_EARLY_EXIT_EN
  // MSB-first: job step idx addresses slice NSLICE-1-idx
  assign sel    = IDXW'(NSLICE - 1) - idx_q;
  assign finish = last || !cmp_E;
`else
  assign sel    = idx_q;
  assign finish = last;
`endif

  assign bus.busy = (state_q == RUN);
  assign bus.done = done_q;
  assign bus.eq   = eq_q;
  assign bus.lt   = lt_q;
  assign bus.gt   = gt_q;
  assign bus.err  = err_q;

  // Comparator feed: selected slice plus cascade inputs while running, neutral when idle
  always_comb begin
    cmp_a                 = '0;
    cmp_b                 = '0;
    {cmp_e, cmp_l, cmp_g} = 3'b100;
    if (state_q == RUN) begin
      for (int unsigned i = 0; i < NSLICE; i++) begin
        if (IDXW'(i) == sel) begin
          cmp_a = opa_q[i*SLICE_W +: SLICE_W];
          cmp_b = opb_q[i*SLICE_W +: SLICE_W];
        end
      end
`ifndef CMP_EARLY_EXIT_EN
      {cmp_e, cmp_l, cmp_g} = casc_q;
`endif
    end
  end

  // Job sequencing: accept, per-slice step, result capture and done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      eq_q    <= 1'b1;
      lt_q    <= 1'b0;
      gt_q    <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
`ifndef CMP_EARLY_EXIT_EN
      casc_q  <= 3'b100;
`endif
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        state_q <= RUN;
        idx_q   <= '0;
        opa_q   <= bus.op_a;
        opb_q   <= bus.op_b;
        err_q   <= 1'b0;
`ifndef CMP_EARLY_EXIT_EN
        casc_q  <= 3'b100;
`endif
      end else if (state_q == RUN) begin
        err_q <= err_q | ~res_onehot;
        idx_q <= idx_q + 1'b1;
`ifndef CMP_EARLY_EXIT_EN
        casc_q <= {cmp_E, cmp_L, cmp_G};
`endif
        if (finish) begin
          eq_q    <= cmp_E;
          lt_q    <= cmp_L;
          gt_q    <= cmp_G;
          done_q  <= 1'b1;
          state_q <= IDLE;
          idx_q   <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cmp_seq_ctrl.sv
// Testbench for cmp_seq_ctrl (SLICE_W=16, NSLICE=4) with a behavioural
// hex_comparator attached. Honours CMP_EARLY_EXIT_EN for expected latencies.
module tb_cmp_seq_ctrl;
  localparam int unsigned SLICE_W = 16;
  localparam int unsigned NSLICE  = 4;
  localparam int unsigned W       = SLICE_W * NSLICE;
`ifdef CMP_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cmp_seq_ctrl_if #(.SLICE_W(SLICE_W), .NSLICE(NSLICE)) bus ();

  logic [SLICE_W-1:0] cmp_a, cmp_b;
  logic cmp_e, cmp_l, cmp_g, cmp_E, cmp_L, cmp_G;
  logic force_bad;

  cmp_seq_ctrl #(.SLICE_W(SLICE_W), .NSLICE(NSLICE)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .cmp_a(cmp_a), .cmp_b(cmp_b),
    .cmp_e(cmp_e), .cmp_l(cmp_l), .cmp_g(cmp_g),
    .cmp_E(cmp_E), .cmp_L(cmp_L), .cmp_G(cmp_G)
  );

  // Behavioural hex_comparator: magnitude decides, equal slices pass cascade through
  always_comb begin
    if (force_bad)          {cmp_E, cmp_L, cmp_G} = 3'b110;
    else if (cmp_a > cmp_b) {cmp_E, cmp_L, cmp_G} = 3'b001;
    else if (cmp_a < cmp_b) {cmp_E, cmp_L, cmp_G} = 3'b010;
    else                    {cmp_E, cmp_L, cmp_G} = {cmp_e, cmp_l, cmp_g};
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain magnitude compare; latency from first differing slice when exiting early
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [2:0] elg, output int lat);
    bit found = 1'b0;
    elg = {a == b, a < b, a > b};
    lat = NSLICE;
    if (EARLY) begin
      for (int s = NSLICE - 1; s >= 0; s--) begin
        if (!found && (a[s*SLICE_W +: SLICE_W] != b[s*SLICE_W +: SLICE_W])) begin
          found = 1'b1;
          lat   = NSLICE - s;
        end
      end
    end
  endfunction

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start = 1'b1;
    bus.op_a  = a;
    bus.op_b  = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Bounded wait for done; optionally pokes start/operands while busy
  task automatic wait_done(input bit inject, output int lat, output bit seen);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      if (inject && ($urandom_range(0, 2) == 0)) begin
        bus.start = 1'b1;
        bus.op_a  = {$urandom, $urandom};
        bus.op_b  = {$urandom, $urandom};
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      lat++;
      if (bus.done) seen = 1'b1;
    end
  endtask

  task automatic model_job(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input bit inject);
    logic [2:0] elg;
    int elat, lat;
    bit seen;
    model(a, b, elg, elat);
    launch(a, b);
    chk({tag, "_busy"}, bus.busy, 1);
    chk({tag, "_errclr"}, bus.err, 0);
    wait_done(inject, lat, seen);
    chk({tag, "_done"}, seen, 1);
    chk({tag, "_lat"}, lat, elat);
    chk({tag, "_elg"}, {bus.eq, bus.lt, bus.gt}, elg);
    chk({tag, "_err"}, bus.err, 0);
    chk({tag, "_idle"}, bus.busy, 0);
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   elg;
    int           lat_lsb;
    int           lat_msb;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, cyc_first, ndone;
    bit seen;
    logic [2:0] res;
    logic [W-1:0] a, b;

    tbl[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3'b100, 4, 4};
    tbl[1] = '{64'h8000_0000_0000_0000, 64'h0,                   3'b001, 4, 1};
    tbl[2] = '{64'h0,                   64'h8000_0000_0000_0000, 3'b010, 4, 1};
    tbl[3] = '{64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 3'b010, 4, 4};
    tbl[4] = '{64'h0,                   64'h0,                   3'b100, 4, 4};
    tbl[5] = '{64'h0000_0001_0000_0000, 64'h0000_0000_FFFF_FFFF, 3'b001, 4, 2};

    force_bad = 1'b0;
    bus.start = 1'b0;
    bus.op_a  = '0;
    bus.op_b  = '0;

    // Reset state
    @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_elg", {bus.eq, bus.lt, bus.gt}, 3'b100);
    chk("rst_err", bus.err, 0);
    chk("rst_casc", {cmp_e, cmp_l, cmp_g}, 3'b100);
    chk("rst_cmpab", {cmp_a, cmp_b}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors
    foreach (tbl[i]) begin
      @(negedge clk);
      launch(tbl[i].a, tbl[i].b);
      wait_done(1'b0, lat, seen);
      chk($sformatf("vec%0d_done", i), seen, 1);
      chk($sformatf("vec%0d_lat", i), lat, EARLY ? tbl[i].lat_msb : tbl[i].lat_lsb);
      chk($sformatf("vec%0d_elg", i), {bus.eq, bus.lt, bus.gt}, tbl[i].elg);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_pulse", i), bus.done, 0);
      chk($sformatf("vec%0d_hold", i), {bus.eq, bus.lt, bus.gt}, tbl[i].elg);
    end

    // Back-to-back: second start lands in the done cycle
    @(negedge clk);
    model_job("b2b1", 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    chk("b2b_donecyc", bus.done, 1);
    model_job("b2b2", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);

    // Start pulsed mid-job with swapped operands must be ignored
    @(negedge clk);
    launch(64'h1, 64'h0);
    cyc_first = 0;
    ndone = 0;
    res = '0;
    for (int c = 1; c <= 10; c++) begin
      if (c == 3) begin
        bus.start = 1'b1;
        bus.op_a  = 64'h0;
        bus.op_b  = 64'h1;
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      if (bus.done) begin
        ndone++;
        if (cyc_first == 0) cyc_first = c;
      end
      if (c == 4) res = {bus.eq, bus.lt, bus.gt};
    end
    chk("ign_first", cyc_first, 4);
    chk("ign_count", ndone, 1);
    chk("ign_elg", res, 3'b001);

    // Reset at T2 of a job: immediate reset values, no done, then normal job
    @(negedge clk);
    launch(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", bus.busy, 0);
    chk("mrst_done", bus.done, 0);
    chk("mrst_elg", {bus.eq, bus.lt, bus.gt}, 3'b100);
    chk("mrst_casc", {cmp_e, cmp_l, cmp_g}, 3'b100);
    chk("mrst_cmpab", {cmp_a, cmp_b}, 0);
    ndone = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (bus.done) ndone++;
    end
    chk("mrst_nodone", ndone, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    model_job("post_rst", 64'h0000_0000_0001_0000, 64'h0000_0000_0000_FFFF, 1'b0);

    // Non-one-hot comparator result raises err, held until the next accept
    force_bad = 1'b1;
    @(negedge clk);
    launch(64'h5555_0000_AAAA_1111, 64'h0123_4567_89AB_CDEF);
    wait_done(1'b0, lat, seen);
    chk("bad_done", seen, 1);
    chk("bad_lat", lat, NSLICE);
    chk("bad_err", bus.err, 1);
    chk("bad_elg", {bus.eq, bus.lt, bus.gt}, 3'b110);
    force_bad = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("bad_hold", bus.err, 1);
    @(negedge clk);
    model_job("bad_clear", 64'h5, 64'h5, 1'b0);

    // Randomized jobs against the reference model
    for (int n = 0; n < 150; n++) begin
      a = {$urandom, $urandom};
      b = a;
      for (int s = 0; s < NSLICE; s++)
        if ($urandom_range(0, 2) == 0) b[s*SLICE_W +: SLICE_W] = SLICE_W'($urandom);
      if ($urandom_range(0, 7) == 0) b = {$urandom, $urandom};
      @(negedge clk);
      model_job($sformatf("rnd%0d", n), a, b, ($urandom_range(0, 1) == 1));
      @(posedge clk);
      #1;
      chk($sformatf("rnd%0d_pulse", n), bus.done, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cmp_seq_ctrl.md
Name: cmp_seq_ctrl

Overview:
Sequencer that compares two wide operands (SLICE_W*NSLICE bits) using one shared 16-bit hex_comparator. It feeds one slice per cycle and chains the comparator's cascade inputs (e/l/g) from the previous slice's result. It sits between a requesting datapath and a single external hex_comparator instance, and reports eq/lt/gt with a start/done handshake.

Parameters:
SLICE_W, 16, width of one comparator slice (matches hex_comparator a/b)
NSLICE, 4, number of slices per operand; operand width = SLICE_W*NSLICE; legal range 1..16

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request; accepted only when busy=0
op_a  in  SLICE_W*NSLICE  operand A, sampled on accepted start
op_b  in  SLICE_W*NSLICE  operand B, sampled on accepted start
busy  out  1  high from the accepting edge until the result edge
done  out  1  one-cycle pulse when eq/lt/gt become valid
eq  out  1  A==B, held until next accepted start
lt  out  1  A<B, held
gt  out  1  A>B, held
err  out  1  comparator returned a non-one-hot E/L/G during the job, held
cmp_a  out  SLICE_W  slice of A to comparator a
cmp_b  out  SLICE_W  slice of B to comparator b
cmp_e  out  1  cascade-in e to comparator
cmp_l  out  1  cascade-in l
cmp_g  out  1  cascade-in g
cmp_E  in  1  comparator E result (combinational from cmp_*)
cmp_L  in  1  comparator L result
cmp_G  in  1  comparator G result

Behaviour:
- Reset (async, rst_n=0): state=IDLE, busy=0, done=0, eq=1, lt=0, gt=0, err=0, slice index=0, cascade reg={e,l,g}={1,0,0}, operand regs=0.
- States: IDLE -> RUN on start && !busy; RUN -> IDLE after the last slice. DONE is not a state; done is a registered pulse.
- Accepting edge T0: latch op_a/op_b, idx=0, cascade={1,0,0}, busy=1. eq/lt/gt/err keep their previous values until the result edge.
- RUN, default LSB-first: cmp_a/cmp_b = slice idx (idx 0 = bits SLICE_W-1:0); cmp_e/l/g = cascade reg. At each edge, cascade <= {cmp_E,cmp_L,cmp_G}, idx++.
- err <= err | !onehot(cmp_E,cmp_L,cmp_G) on every RUN edge. It is cleared on the accepting edge.
- Result edge T(NSLICE): {eq,lt,gt} <= {cmp_E,cmp_L,cmp_G} of the last slice; done=1 for exactly one cycle; busy=0. Fixed latency is NSLICE cycles from the accepting edge.
- IDLE outputs: cmp_a=0, cmp_b=0, cmp_e=1, cmp_l=0, cmp_g=0.
- start while busy=1: ignored, no queuing.
- start in the cycle done=1: accepted (busy already 0), giving back-to-back jobs with no bubble.
- op_a/op_b changing during RUN: no effect, because the operands are registered.
- NSLICE=1: one RUN cycle, done at T1.
- rst_n low mid-RUN: immediate return to reset values. No done pulse. The partial job is lost.

Optional Feature:
CMP_EARLY_EXIT_EN
- Defined: slices are fed MSB-first (idx 0 = top slice). Cascade inputs are held at {1,0,0} for every slice.
- On the first edge where cmp_E=0, the block latches lt/gt from that slice, pulses done and returns to IDLE. Latency is 1..NSLICE cycles.
- All-equal operands still take NSLICE cycles and give eq=1.
- err checking is unchanged.
- Undefined: LSB-first cascade chaining with fixed latency, as described above.

Test Plan:
(All cases use SLICE_W=16, NSLICE=4 with a behavioural hex_comparator attached, unless stated otherwise.)
- After reset: eq=1, lt=0, gt=0, busy=0, done=0, cmp_e=1. Start with A=B=64'hFFFF_FFFF_FFFF_FFFF -> done at T4, eq=1, lt=0, gt=0.
- A=64'h8000_0000_0000_0000, B=0 -> gt=1 at T4. Swap operands -> lt=1.
- A=64'hFFFF_FFFF_FFFF_FFFE, B=64'hFFFF_FFFF_FFFF_FFFF -> lt=1 (LSB difference carried through cascade). Then A=64'hFFFF_FFFF_FFFF_FFFF, B=64'hFFFF_FFFF_FFFF_FFFE -> gt=1, run back-to-back with start asserted on the done cycle.
- Pulse start again at T2 of a running job with different operands -> ignored; the first job's result appears at T4; exactly one done pulse.
- Assert rst_n=0 at T2 of a job -> outputs return to reset values immediately, no done. Then a new start completes normally.
- With CMP_EARLY_EXIT_EN: A=64'h8000_0000_0000_0000, B=0 -> done at T1, gt=1. A=B=0 -> done at T4, eq=1. Force the comparator stub to return E=L=1 -> err=1, held until the next start.
